// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-set controller.
// Contents: FSM state encoding, BCD digit limits, a two-digit BCD field type
// and the capture sanitisation helper.
package watch_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      EDIT_SEC = 2'd1,
      EDIT_MIN = 2'd2,
      COMMIT   = 2'd3
   } state_t;

   localparam logic [3:0] BCD_ONES_MAX = 4'd9;
   localparam logic [3:0] BCD_TENS_MAX = 4'd5;

   // One mm or ss field as two BCD digits.
   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   // A captured field that is not a legal 00..59 value is replaced by 00.
   function automatic bcd2_t bcd_sanitise(input bcd2_t v);
      bcd2_t r;
      r = v;
      if ((v.ones > BCD_ONES_MAX) || (v.tens > BCD_TENS_MAX)) begin
         r = '0;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd60_step.sv
// Combinational one-step mod-60 BCD increment/decrement of a two-digit field.
// Ports:
//   cur - current {tens, ones}
//   dir - 0 = increment, 1 = decrement
//   nxt - {tens, ones} after one step, wrapping 59 <-> 00
module bcd60_step
   import watch_pkg::*;
(
   input  bcd2_t cur,
   input  logic  dir,
   output bcd2_t nxt
);

   always_comb begin
      nxt = cur;
      if (!dir) begin
         if (cur.ones < BCD_ONES_MAX) begin
            nxt.ones = cur.ones + 4'd1;
         end else begin
            nxt.ones = 4'd0;
            nxt.tens = (cur.tens < BCD_TENS_MAX) ? (cur.tens + 4'd1) : 4'd0;
         end
      end else begin
         if (cur.ones > 4'd0) begin
            nxt.ones = cur.ones - 4'd1;
         end else begin
            nxt.ones = BCD_ONES_MAX;
            nxt.tens = (cur.tens > 4'd0) ? (cur.tens - 4'd1) : BCD_TENS_MAX;
         end
      end
   end

endmodule

// File: rtl/watch_time_set_ctrl.sv
// Time-set controller for the MM:SS counters. Button pulses edit a shadow copy
// of the time; on commit the shadow is loaded into the live counters.
// Optional macro WATCH_SET_DEC_EN adds btn_dec_p (decrement edited field).
// Ports:
//   clk, reset_p                 - clock, asynchronous active-high reset
//   btn_mode_p/sel_p/inc_p       - one-cycle button pulses (mode > sel > inc)
//   btn_dec_p                    - decrement pulse (WATCH_SET_DEC_EN only)
//   cur_sec1/sec10/min1/min10    - live counter digits, captured on edit entry
//   set_mode                     - high while editing or committing
//   load_sec, load_min           - one-cycle load enables to the counters
//   set_sec1/sec10/min1/min10    - shadow digits for the counters' set_value
//   blink_mask                   - {min10,min1,sec10,sec1}, 1 = blank digit
module watch_time_set_ctrl
   import watch_pkg::*;
#(
   parameter int unsigned BLINK_CNT = 50_000_000
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       btn_mode_p,
   input  logic       btn_sel_p,
   input  logic       btn_inc_p,
`ifdef WATCH_SET_DEC_EN
   input  logic       btn_dec_p,
`endif
   input  logic [3:0] cur_sec1,
   input  logic [3:0] cur_sec10,
   input  logic [3:0] cur_min1,
   input  logic [3:0] cur_min10,
   output logic       set_mode,
   output logic       load_sec,
   output logic       load_min,
   output logic [3:0] set_sec1,
   output logic [3:0] set_sec10,
   output logic [3:0] set_min1,
   output logic [3:0] set_min10,
   output logic [3:0] blink_mask
);

   localparam int unsigned   CNT_W    = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CNT - 1);

   state_t           state;
   bcd2_t            sec_q;
   bcd2_t            min_q;
   bcd2_t            sec_step;
   bcd2_t            min_step;
   logic [CNT_W-1:0] blink_cnt;
   logic             blink_phase;
   logic             cnt_wrap;
   logic             phase_adv;
   logic             step_en;
   logic             step_dir;

   // Step request; inc outranks dec when both arrive together.
`ifdef WATCH_SET_DEC_EN
   assign step_en  = btn_inc_p | btn_dec_p;
   assign step_dir = ~btn_inc_p;
`else
   assign step_en  = btn_inc_p;
   assign step_dir = 1'b0;
`endif

   bcd60_step u_sec_step (.cur(sec_q), .dir(step_dir), .nxt(sec_step));
   bcd60_step u_min_step (.cur(min_q), .dir(step_dir), .nxt(min_step));

   assign cnt_wrap  = (blink_cnt == CNT_LAST);
   assign phase_adv = blink_phase ^ cnt_wrap;

   assign set_sec1  = sec_q.ones;
   assign set_sec10 = sec_q.tens;
   assign set_min1  = min_q.ones;
   assign set_min10 = min_q.tens;

   // Edit FSM with shadow registers, blink timer and registered outputs.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state       <= RUN;
         sec_q       <= '0;
         min_q       <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         set_mode    <= 1'b0;
         load_sec    <= 1'b0;
         load_min    <= 1'b0;
         blink_mask  <= 4'b0000;
      end else begin
         load_sec <= 1'b0;
         load_min <= 1'b0;
         case (state)
            RUN: begin
               if (btn_mode_p) begin
                  state       <= EDIT_SEC;
                  sec_q       <= bcd_sanitise({cur_sec10, cur_sec1});
                  min_q       <= bcd_sanitise({cur_min10, cur_min1});
                  blink_cnt   <= '0;
                  blink_phase <= 1'b0;
                  set_mode    <= 1'b1;
                  blink_mask  <= 4'b0000;
               end
            end
            EDIT_SEC, EDIT_MIN: begin
               if (btn_mode_p) begin
                  state      <= COMMIT;
                  load_sec   <= 1'b1;
                  load_min   <= 1'b1;
                  blink_mask <= 4'b0000;
               end else if (btn_sel_p) begin
                  // Field toggle restarts the blink so the new field starts visible.
                  state       <= (state == EDIT_SEC) ? EDIT_MIN : EDIT_SEC;
                  blink_cnt   <= '0;
                  blink_phase <= 1'b0;
                  blink_mask  <= 4'b0000;
               end else begin
                  if (step_en) begin
                     if (state == EDIT_SEC) sec_q <= sec_step;
                     else                   min_q <= min_step;
                  end
                  blink_cnt   <= cnt_wrap ? '0 : (blink_cnt + CNT_W'(1));
                  blink_phase <= phase_adv;
                  blink_mask  <= !phase_adv ? 4'b0000 :
                                 (state == EDIT_SEC) ? 4'b0011 : 4'b1100;
               end
            end
            COMMIT: begin
               state    <= RUN;
               set_mode <= 1'b0;
            end
            default: begin
               state    <= RUN;
               set_mode <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_watch_time_set_ctrl.sv
// Self-checking bench for watch_time_set_ctrl (BLINK_CNT = 4).
// Table-driven edit/commit vectors, hand-written reset and blink sequences,
// then randomized pulses checked against a field-value reference model.
// Build with WATCH_SET_DEC_EN defined to also exercise btn_dec_p.
module tb_watch_time_set_ctrl;

   localparam int BLINK = 4;

   logic       clk = 1'b0;
   logic       reset_p;
   logic       btn_mode_p, btn_sel_p, btn_inc_p;
`ifdef WATCH_SET_DEC_EN
   logic       btn_dec_p;
`endif
   logic [3:0] cur_sec1, cur_sec10, cur_min1, cur_min10;
   logic       set_mode, load_sec, load_min;
   logic [3:0] set_sec1, set_sec10, set_min1, set_min10;
   logic [3:0] blink_mask;

   int checks   = 0;
   int failures = 0;

   // Reference model: edit mode (0 run, 1 sec, 2 min, 3 commit), field values
   // as plain integers 0..59, and edit cycles since the last blink restart.
   int m_st, m_sec, m_min, m_t;

   watch_time_set_ctrl #(.BLINK_CNT(BLINK)) dut (
      .clk        (clk),
      .reset_p    (reset_p),
      .btn_mode_p (btn_mode_p),
      .btn_sel_p  (btn_sel_p),
      .btn_inc_p  (btn_inc_p),
`ifdef WATCH_SET_DEC_EN
      .btn_dec_p  (btn_dec_p),
`endif
      .cur_sec1   (cur_sec1),
      .cur_sec10  (cur_sec10),
      .cur_min1   (cur_min1),
      .cur_min10  (cur_min10),
      .set_mode   (set_mode),
      .load_sec   (load_sec),
      .load_min   (load_min),
      .set_sec1   (set_sec1),
      .set_sec10  (set_sec10),
      .set_min1   (set_min1),
      .set_min10  (set_min10),
      .blink_mask (blink_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_sec = 0; m_min = 0; m_t = 0;
   endtask

   function automatic int capture(input int tens, input int ones);
      return (tens <= 5 && ones <= 9) ? tens * 10 + ones : 0;
   endfunction

   task automatic model_step(input logic mode, input logic sel, input logic inc,
                             input logic dec, input int cs10, input int cs1,
                             input int cm10, input int cm1);
      case (m_st)
         0: if (mode) begin
               m_sec = capture(cs10, cs1);
               m_min = capture(cm10, cm1);
               m_st  = 1;
               m_t   = 0;
            end
         1, 2: begin
            if (mode) m_st = 3;
            else if (sel) begin
               m_st = 3 - m_st;
               m_t  = 0;
            end else begin
               if (inc || dec) begin
                  if (m_st == 1) m_sec = (m_sec + (inc ? 1 : 59)) % 60;
                  else           m_min = (m_min + (inc ? 1 : 59)) % 60;
               end
               m_t++;
            end
         end
         default: m_st = 0;
      endcase
   endtask

   function automatic int model_mask();
      if (((m_t / BLINK) % 2) == 0) return 0;
      if (m_st == 1) return 3;
      if (m_st == 2) return 12;
      return 0;
   endfunction

   task automatic check_model(input string tag);
      chk({tag, "_set_mode"}, int'(set_mode), int'(m_st != 0));
      chk({tag, "_load_sec"}, int'(load_sec), int'(m_st == 3));
      chk({tag, "_load_min"}, int'(load_min), int'(m_st == 3));
      chk({tag, "_sec10"}, int'(set_sec10), m_sec / 10);
      chk({tag, "_sec1"},  int'(set_sec1),  m_sec % 10);
      chk({tag, "_min10"}, int'(set_min10), m_min / 10);
      chk({tag, "_min1"},  int'(set_min1),  m_min % 10);
      chk({tag, "_mask"},  int'(blink_mask), model_mask());
   endtask

   // Drive one cycle of pulses, advance the model, sample #1 after the edge.
   task automatic cycle(input logic mode, input logic sel, input logic inc, input logic dec,
                        input logic [3:0] cs10, input logic [3:0] cs1,
                        input logic [3:0] cm10, input logic [3:0] cm1);
      @(negedge clk);
      btn_mode_p = mode; btn_sel_p = sel; btn_inc_p = inc;
`ifdef WATCH_SET_DEC_EN
      btn_dec_p = dec;
`endif
      cur_sec10 = cs10; cur_sec1 = cs1; cur_min10 = cm10; cur_min1 = cm1;
      @(posedge clk);
      #1;
      model_step(mode, sel, inc, dec, int'(cs10), int'(cs1), int'(cm10), int'(cm1));
      btn_mode_p = 1'b0; btn_sel_p = 1'b0; btn_inc_p = 1'b0;
`ifdef WATCH_SET_DEC_EN
      btn_dec_p = 1'b0;
`endif
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
   endtask

   // Async reset asserted between edges; outputs must clear before any clock.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 reset_p = 1'b1;
      #1;
      chk({tag, "_set_mode"}, int'(set_mode), 0);
      chk({tag, "_loads"},    int'({load_sec, load_min}), 0);
      chk({tag, "_set_all"},  int'({set_min10, set_min1, set_sec10, set_sec1}), 0);
      chk({tag, "_mask"},     int'(blink_mask), 0);
      model_reset();
      #1 reset_p = 1'b0;
   endtask

   typedef struct {
      logic       mode, sel, inc;
      logic [3:0] cs10, cs1, cm10, cm1;
      logic       e_mode, e_load;
      int         e_sec, e_min;
      logic [3:0] e_mask;
   } vec_t;

   vec_t vt[13];
   int   blink_exp[12];
   int   sel_exp[5];

   initial begin
      reset_p = 1'b1;
      btn_mode_p = 1'b0; btn_sel_p = 1'b0; btn_inc_p = 1'b0;
`ifdef WATCH_SET_DEC_EN
      btn_dec_p = 1'b0;
`endif
      cur_sec1 = 4'd0; cur_sec10 = 4'd0; cur_min1 = 4'd0; cur_min10 = 4'd0;
      model_reset();

      // mode, sel, inc, cur s10,s1,m10,m1, exp set_mode, load, sec, min, mask
      vt[0]  = '{1'b1, 1'b0, 1'b0, 4'd5, 4'd8, 4'd0, 4'd7, 1'b1, 1'b0, 58,  7, 4'd0};
      vt[1]  = '{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 59,  7, 4'd0};
      vt[2]  = '{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0,  0,  7, 4'd0};
      vt[3]  = '{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0,  1,  7, 4'd0};
      vt[4]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1,  1,  7, 4'd0};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0,  1,  7, 4'd0};
      vt[6]  = '{1'b1, 1'b0, 1'b0, 4'd6, 4'd3, 4'd5, 4'd9, 1'b1, 1'b0,  0, 59, 4'd0};
      vt[7]  = '{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0,  1, 59, 4'd0};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0,  1, 59, 4'd0};
      vt[9]  = '{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0,  1,  0, 4'd0};
      vt[10] = '{1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0,  1,  0, 4'd0};
      vt[11] = '{1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1,  1,  0, 4'd0};
      vt[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0,  1,  0, 4'd0};

      blink_exp = '{0, 0, 0, 0, 3, 3, 3, 3, 0, 0, 0, 0};
      sel_exp   = '{0, 0, 0, 0, 12};

      #12;
      chk("reset_set_mode", int'(set_mode), 0);
      chk("reset_loads", int'({load_sec, load_min}), 0);
      chk("reset_set_all", int'({set_min10, set_min1, set_sec10, set_sec1}), 0);
      chk("reset_mask", int'(blink_mask), 0);
      @(negedge clk);
      reset_p = 1'b0;

      // Table: capture, inc wrap 59->00, commit, sanitise, priorities.
      for (int i = 0; i < 13; i++) begin
         cycle(vt[i].mode, vt[i].sel, vt[i].inc, 1'b0,
               vt[i].cs10, vt[i].cs1, vt[i].cm10, vt[i].cm1);
         chk($sformatf("vec%0d_set_mode", i), int'(set_mode), int'(vt[i].e_mode));
         chk($sformatf("vec%0d_load_sec", i), int'(load_sec), int'(vt[i].e_load));
         chk($sformatf("vec%0d_load_min", i), int'(load_min), int'(vt[i].e_load));
         chk($sformatf("vec%0d_sec", i), int'({set_sec10, set_sec1}),
             ((vt[i].e_sec / 10) << 4) | (vt[i].e_sec % 10));
         chk($sformatf("vec%0d_min", i), int'({set_min10, set_min1}),
             ((vt[i].e_min / 10) << 4) | (vt[i].e_min % 10));
         chk($sformatf("vec%0d_mask", i), int'(blink_mask), int'(vt[i].e_mask));
      end

      // Reset in the middle of editing minutes with shadow 12:34.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd4, 4'd1, 4'd2);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      check_model("pre_rst");
      chk("pre_rst_min", int'({set_min10, set_min1}), 8'h12);
      async_reset("midedit_rst");
      idle();
      check_model("post_rst");

      // Blink cadence in EDIT_SEC, then restart by sel into EDIT_MIN.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("blink_0", int'(blink_mask), blink_exp[0]);
      for (int k = 1; k < 12; k++) begin
         idle();
         chk($sformatf("blink_%0d", k), int'(blink_mask), blink_exp[k]);
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("blink_sel_0", int'(blink_mask), sel_exp[0]);
      for (int k = 1; k < 5; k++) begin
         idle();
         chk($sformatf("blink_sel_%0d", k), int'(blink_mask), sel_exp[k]);
      end
`ifdef WATCH_SET_DEC_EN
      // Back to seconds (captured 00) and decrement: 00 -> 59.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("dec_wrap_sec", int'({set_sec10, set_sec1}), 8'h59);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("inc_over_dec", int'({set_sec10, set_sec1}), 8'h00);
`endif
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      check_model("blink_commit");
      idle();
      check_model("blink_run");

      // Randomized pulses and live digits against the reference model.
      for (int n = 0; n < 3000; n++) begin
         logic       r_mode, r_sel, r_inc, r_dec;
         logic [3:0] s10, s1, mm10, mm1;
         r_mode = ($urandom_range(0, 9) == 0);
         r_sel  = ($urandom_range(0, 6) == 0);
         r_inc  = ($urandom_range(0, 2) == 0);
`ifdef WATCH_SET_DEC_EN
         r_dec  = ($urandom_range(0, 2) == 0);
`else
         r_dec  = 1'b0;
`endif
         s10  = 4'($urandom_range(0, 7));
         s1   = 4'($urandom_range(0, 11));
         mm10 = 4'($urandom_range(0, 7));
         mm1  = 4'($urandom_range(0, 11));
         if ($urandom_range(0, 499) == 0) begin
            async_reset("rand_rst");
         end else begin
            cycle(r_mode, r_sel, r_inc, r_dec, s10, s1, mm10, mm1);
            check_model("rand");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
